// File: rtl/pulse_count_datapath_if.sv
// Bus bundle for pulse_count_datapath: count requests, capture strobe, mode select and captured results.
interface pulse_count_datapath_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       INC;
  logic                      LOAD;
  logic                      SAT_MODE;
  logic [CHANNELS*WIDTH-1:0] OUT_REG;
  logic [CHANNELS-1:0]       OVF_REG;
  logic                      LOAD_VALID;

  modport master (
    output INC, LOAD, SAT_MODE,
    input  OUT_REG, OVF_REG, LOAD_VALID
  );

  modport slave (
    input  INC, LOAD, SAT_MODE,
    output OUT_REG, OVF_REG, LOAD_VALID
  );
endinterface

// File: rtl/pulse_count_datapath.sv
// Per-channel pulse counters with wrap/saturate, sticky overflow and LOAD-triggered capture.
// Macro PULSE_EDGE_EN: count rising edges of INC instead of high levels.
module pulse_count_datapath #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
) (
  input logic                    SYS_CLK,
  input logic                    SCLR,
  pulse_count_datapath_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]          cnt_q    [CHANNELS];
  logic [WIDTH-1:0]          cnt_d    [CHANNELS];
  logic [CHANNELS-1:0]       sticky_q, sticky_d;
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;
  logic [CHANNELS-1:0]       ovf_q, ovf_d;
  logic                      load_valid_q, load_valid_d;
  logic [CHANNELS-1:0]       ev;

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] c, input logic sat);
    if (c == CNT_MAX) return sat ? CNT_MAX : '0;
    return c + WIDTH'(1);
  endfunction

`ifdef PULSE_EDGE_EN
  logic [CHANNELS-1:0] inc_hist_q;

  always_ff @(posedge SYS_CLK) begin
    if (SCLR) inc_hist_q <= '0;
    else      inc_hist_q <= bus.INC;
  end

  assign ev = bus.INC & ~inc_hist_q;
`else
  assign ev = bus.INC;
`endif

  always_comb begin
    out_d        = out_q;
    ovf_d        = ovf_q;
    sticky_d     = sticky_q;
    load_valid_d = bus.LOAD;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.LOAD) begin
        // Events coincident with LOAD open the new interval.
        out_d[i*WIDTH +: WIDTH] = cnt_q[i];
        ovf_d[i]                = sticky_q[i];
        cnt_d[i]                = ev[i] ? WIDTH'(1) : '0;
        sticky_d[i]             = 1'b0;
      end else if (ev[i]) begin
        cnt_d[i] = bump(cnt_q[i], bus.SAT_MODE);
        if (cnt_q[i] == CNT_MAX) sticky_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SCLR) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      sticky_q     <= '0;
      out_q        <= '0;
      ovf_q        <= '0;
      load_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      sticky_q     <= sticky_d;
      out_q        <= out_d;
      ovf_q        <= ovf_d;
      load_valid_q <= load_valid_d;
    end
  end

  assign bus.OUT_REG    = out_q;
  assign bus.OVF_REG    = ovf_q;
  assign bus.LOAD_VALID = load_valid_q;

endmodule

// File: tb/tb_pulse_count_datapath.sv
// Self-checking bench for pulse_count_datapath: vector table, corner sequences and randomized run against a count model.
module tb_pulse_count_datapath;
  localparam int W   = 5;
  localparam int CH  = 4;
  localparam int MAX = (1 << W) - 1;

  logic SYS_CLK = 1'b0;
  logic SCLR    = 1'b1;

  pulse_count_datapath_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pulse_count_datapath #(.WIDTH(W), .CHANNELS(CH)) dut (
    .SYS_CLK (SYS_CLK),
    .SCLR    (SCLR),
    .bus     (bus)
  );

  always #50 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer counts per channel.
  int m_cnt [CH];
  bit m_sticky [CH];
  int m_out [CH];
  bit m_ovf [CH];
  bit m_lv;
  bit m_hist [CH];

  typedef struct {
    bit sat;
    int ch;
    int ncyc;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ev;
    if (SCLR) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_sticky[i] = 0; m_out[i] = 0; m_ovf[i] = 0; m_hist[i] = 0;
      end
      m_lv = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
`ifdef PULSE_EDGE_EN
        ev = bus.INC[i] && !m_hist[i];
`else
        ev = bus.INC[i];
`endif
        if (bus.LOAD) begin
          m_out[i]    = m_cnt[i];
          m_ovf[i]    = m_sticky[i];
          m_cnt[i]    = ev ? 1 : 0;
          m_sticky[i] = 0;
        end else if (ev) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] > MAX) begin
            m_sticky[i] = 1;
            m_cnt[i]    = bus.SAT_MODE ? MAX : 0;
          end
        end
        m_hist[i] = bus.INC[i];
      end
      m_lv = bus.LOAD;
    end
  endtask

  task automatic compare_model();
    logic [CH*W-1:0] e_out;
    logic [CH-1:0]   e_ovf;
    for (int i = 0; i < CH; i++) begin
      e_out[i*W +: W] = W'(m_out[i]);
      e_ovf[i]        = m_ovf[i];
    end
    chk("model_out_reg", 32'(bus.OUT_REG), 32'(e_out));
    chk("model_ovf_reg", 32'(bus.OVF_REG), 32'(e_ovf));
    chk("model_load_valid", 32'(bus.LOAD_VALID), 32'(m_lv));
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic apply_vec(input vec_t v);
    SCLR = 1'b1; bus.INC = '0; bus.LOAD = 1'b0;
    tick();
    SCLR = 1'b0; bus.SAT_MODE = v.sat; bus.INC = CH'(1 << v.ch);
    repeat (v.ncyc) tick();
    bus.INC = '0; bus.LOAD = 1'b1;
    tick();
    bus.LOAD = 1'b0;
    chk("vec_count", 32'(bus.OUT_REG[v.ch*W +: W]), 32'(v.exp_cnt));
    chk("vec_ovf", 32'(bus.OVF_REG[v.ch]), 32'(v.exp_ovf));
    chk("vec_load_valid_hi", 32'(bus.LOAD_VALID), 32'd1);
    tick();
    chk("vec_load_valid_lo", 32'(bus.LOAD_VALID), 32'd0);
    chk("vec_count_stable", 32'(bus.OUT_REG[v.ch*W +: W]), 32'(v.exp_cnt));
  endtask

  initial begin
    bus.INC = '0; bus.LOAD = 1'b0; bus.SAT_MODE = 1'b0;
    SCLR = 1'b1;
    tick();
    chk("reset_no_x", 32'($isunknown({bus.OUT_REG, bus.OVF_REG, bus.LOAD_VALID})), 32'd0);
    chk("reset_out_reg", 32'(bus.OUT_REG), 32'd0);

`ifdef PULSE_EDGE_EN
    vt.push_back('{sat: 0, ch: 3, ncyc: 10, exp_cnt: 1, exp_ovf: 0});
    vt.push_back('{sat: 1, ch: 0, ncyc: 30, exp_cnt: 1, exp_ovf: 0});
    vt.push_back('{sat: 0, ch: 1, ncyc: 33, exp_cnt: 1, exp_ovf: 0});
`else
    vt.push_back('{sat: 0, ch: 0, ncyc: 30, exp_cnt: 30, exp_ovf: 0});
    vt.push_back('{sat: 0, ch: 1, ncyc: 33, exp_cnt: 1,  exp_ovf: 1});
    vt.push_back('{sat: 1, ch: 1, ncyc: 33, exp_cnt: 31, exp_ovf: 1});
    vt.push_back('{sat: 0, ch: 2, ncyc: 31, exp_cnt: 31, exp_ovf: 0});
    vt.push_back('{sat: 0, ch: 3, ncyc: 32, exp_cnt: 0,  exp_ovf: 1});
    vt.push_back('{sat: 1, ch: 3, ncyc: 5,  exp_cnt: 5,  exp_ovf: 0});
`endif
    foreach (vt[k]) apply_vec(vt[k]);

`ifdef PULSE_EDGE_EN
    // Toggling INC[3] gives five rising edges in ten cycles.
    SCLR = 1'b1; tick(); SCLR = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.INC = (c % 2 == 0) ? 4'b1000 : 4'b0000;
      tick();
    end
    bus.INC = '0; bus.LOAD = 1'b1; tick(); bus.LOAD = 1'b0;
    chk("edge_toggle_ch3", 32'(bus.OUT_REG[3*W +: W]), 32'd5);
`else
    // LOAD coincident with a count event: the event opens the new interval.
    SCLR = 1'b1; tick(); SCLR = 1'b0; bus.SAT_MODE = 1'b0;
    bus.INC = 4'b0100;
    repeat (7) tick();
    bus.LOAD = 1'b1; tick(); bus.LOAD = 1'b0;
    chk("coinc_first_capture", 32'(bus.OUT_REG[2*W +: W]), 32'd7);
    repeat (3) tick();
    bus.INC = '0; bus.LOAD = 1'b1; tick(); bus.LOAD = 1'b0;
    chk("coinc_second_capture", 32'(bus.OUT_REG[2*W +: W]), 32'd4);

    // Overflow in the LOAD cycle is not reported.
    SCLR = 1'b1; tick(); SCLR = 1'b0;
    bus.INC = 4'b0001;
    repeat (31) tick();
    bus.LOAD = 1'b1; tick(); bus.LOAD = 1'b0; bus.INC = '0;
    chk("ovf_at_load_count", 32'(bus.OUT_REG[0 +: W]), 32'd31);
    chk("ovf_at_load_flag", 32'(bus.OVF_REG[0]), 32'd0);
`endif

    // SCLR coincident with LOAD discards both counts and capture.
    SCLR = 1'b1; tick(); SCLR = 1'b0;
    bus.INC = 4'b1111;
    repeat (12) tick();
    bus.INC = '0; SCLR = 1'b1; bus.LOAD = 1'b1; tick();
    SCLR = 1'b0; bus.LOAD = 1'b0;
    chk("sclr_load_out", 32'(bus.OUT_REG), 32'd0);
    chk("sclr_load_valid", 32'(bus.LOAD_VALID), 32'd0);
    repeat (3) tick();
    bus.LOAD = 1'b1; tick(); bus.LOAD = 1'b0;
    chk("after_sclr_out", 32'(bus.OUT_REG), 32'd0);
    chk("after_sclr_valid", 32'(bus.LOAD_VALID), 32'd1);

    // Randomized traffic against the model, including held LOAD and mid-run SCLR.
    for (int n = 0; n < 2000; n++) begin
      bus.INC = CH'($urandom);
      bus.LOAD = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) bus.SAT_MODE = ~bus.SAT_MODE;
      SCLR = ($urandom_range(0, 99) == 0);
      tick();
    end
    SCLR = 1'b0; bus.LOAD = 1'b0; bus.INC = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
